pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage ARM-subset pipeline (IF, ID, EXE, MEM, WB).
- Detects RAW hazards between the ID-stage sources and the EXE/MEM destinations. Inserts bubbles by driving flush on the ID/EXE pipeline register and freezing PC and IF/ID.
- Flushes wrong-path instructions on a taken branch.
- Sequences multi-cycle data-memory accesses with a wait-state FSM that freezes the whole pipeline until the access completes.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/mem_wait_fsm.sv | 62 ++++++
 rtl/pipeline_hazard_ctrl.sv | 90 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W          = 4;
  localparam int MEM_WAIT_CYCLES_DEF = 4;
  localparam int WAIT_CNT_W          = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state sequencer: holds freeze_all for MEM_WAIT_CYCLES cycles, then pulses mem_done.
// Combinational outputs from state/counter; a dropped mem_req mid-access is ignored and the count finishes.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic freeze_all,
  output logic mem_done
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(MEM_WAIT_CYCLES - 1);

  mem_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    freeze_raw;
  logic                    done_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freeze_raw = 1'b0;
    done_raw   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d    = ACCESS;
          cnt_d      = CNT_LOAD;
          freeze_raw = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d      = cnt_q - 1'b1;
          freeze_raw = 1'b1;
        end else begin
          done_raw = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE with mem_req would freeze combinationally; reset must release the pipeline at once
  assign freeze_all = freeze_raw & ~rst;
  assign mem_done   = done_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW bubbles, branch flush, memory wait freeze, stall counter.
// Outputs combinational (zero latency); PIPE_HAZARD_FORWARDING_EN limits stalls to load-use hazards.
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT_CYCLES = pipe_ctrl_pkg::MEM_WAIT_CYCLES_DEF,
  parameter int REG_ADDR_W      = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_uses_src1,
  input  logic                   id_two_src,
  input  logic [REG_ADDR_W-1:0]  exe_dest,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0]  mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   mem_req,
  input  logic                   branch_taken,
  output logic                   freeze_if,
  output logic                   flush_if,
  output logic                   flush_id,
  output logic                   freeze_all,
  output logic                   mem_done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic src1_exe, src2_exe;
  logic hz;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign src1_exe = exe_wb_en && (id_src1 == exe_dest);
  assign src2_exe = exe_wb_en && (id_src2 == exe_dest);

`ifdef PIPE_HAZARD_FORWARDING_EN
  // Forwarding covers everything except a load whose data is not back yet
  logic unused_mem_ports;
  assign unused_mem_ports = &{1'b0, mem_dest, mem_wb_en};
  assign hz = exe_mem_r_en & ((id_uses_src1 & src1_exe) | (id_two_src & src2_exe));
`else
  logic src1_mem, src2_mem;
  logic unused_load_flag;
  assign src1_mem = mem_wb_en && (id_src1 == mem_dest);
  assign src2_mem = mem_wb_en && (id_src2 == mem_dest);
  assign unused_load_flag = &{1'b0, exe_mem_r_en};
  assign hz = (id_uses_src1 & (src1_exe | src1_mem)) |
              (id_two_src   & (src2_exe | src2_mem));
`endif

  mem_wait_fsm #(
    .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)
  ) u_mem_wait (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .freeze_all(freeze_all),
    .mem_done  (mem_done)
  );

  // A held EXE/ID pair during a memory wait must not be flushed or re-evaluated
  always_comb begin
    freeze_if = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    if (freeze_all) begin
      freeze_if = 1'b1;
    end else if (branch_taken) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (hz) begin
      freeze_if = 1'b1;
      flush_id  = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((freeze_if | freeze_all) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed vectors push expected outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       two;
    logic [3:0] ed;
    logic       ewb;
    logic       erd;
    logic [3:0] md;
    logic       mwb;
    logic       mreq;
    logic       br;
  } vec_t;

  // {freeze_if, flush_if, flush_id, freeze_all, mem_done}
  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_HAZ  = 5'b10100;
  localparam logic [4:0] E_BR   = 5'b01100;
  localparam logic [4:0] E_MEM  = 5'b10010;
  localparam logic [4:0] E_DONE = 5'b00001;

`ifdef PIPE_HAZARD_FORWARDING_EN
  localparam logic [4:0] E_EXE_ALU = E_NONE;
  localparam logic [4:0] E_MEM_FWD = E_NONE;
`else
  localparam logic [4:0] E_EXE_ALU = E_HAZ;
  localparam logic [4:0] E_MEM_FWD = E_HAZ;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
  logic       id_uses_src1 = 1'b0, id_two_src = 1'b0, exe_wb_en = 1'b0, exe_mem_r_en = 1'b0;
  logic       mem_wb_en = 1'b0, mem_req = 1'b0, branch_taken = 1'b0;

  logic        a_fi, a_fif, a_fid, a_fa, a_md;
  logic [15:0] a_stall;
  logic        b_fi, b_fif, b_fid, b_fa, b_md;
  logic [3:0]  b_stall;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(4), .REG_ADDR_W(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src1(id_uses_src1), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze_if(a_fi), .flush_if(a_fif), .flush_id(a_fid), .freeze_all(a_fa),
    .mem_done(a_md), .stall_cycles(a_stall)
  );

  pipeline_hazard_ctrl #(.MEM_WAIT_CYCLES(4), .REG_ADDR_W(4), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src1(id_uses_src1), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
    .freeze_if(b_fi), .flush_if(b_fif), .flush_id(b_fid), .freeze_all(b_fa),
    .mem_done(b_md), .stall_cycles(b_stall)
  );

  string      name_q[$];
  logic [24:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [15:0] s16 = '0;
  logic [3:0]  s4  = '0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      string       nm;
      logic [24:0] e;
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      cmp({nm, ".ctrl"},      {11'd0, a_fi, a_fif, a_fid, a_fa, a_md}, {11'd0, e[24:20]});
      cmp({nm, ".stall"},     a_stall, e[19:4]);
      cmp({nm, ".sat_ctrl"},  {11'd0, b_fi, b_fif, b_fid, b_fa, b_md}, {11'd0, e[24:20]});
      cmp({nm, ".sat_stall"}, {12'd0, b_stall}, {12'd0, e[3:0]});
    end
  end

  // Called just after a rising edge; inputs hold for one full cycle
  task automatic cyc(input string nm, input logic r, input vec_t v, input logic [4:0] e);
    rst          = r;
    id_src1      = v.s1;
    id_src2      = v.s2;
    id_uses_src1 = v.u1;
    id_two_src   = v.two;
    exe_dest     = v.ed;
    exe_wb_en    = v.ewb;
    exe_mem_r_en = v.erd;
    mem_dest     = v.md;
    mem_wb_en    = v.mwb;
    mem_req      = v.mreq;
    branch_taken = v.br;
    if (r) begin
      s16 = '0;
      s4  = '0;
    end
    name_q.push_back(nm);
    exp_q.push_back({e, s16, s4});
    if (!r && (e[4] || e[1])) begin
      if (s16 != 16'hFFFF) s16 = s16 + 1'b1;
      if (s4 != 4'hF)      s4  = s4 + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle, v;
    idle = '0;

    @(posedge clk);
    #1;
    v = idle; v.mreq = 1'b1;
    cyc("rst_memreq", 1'b1, v, E_NONE);
    cyc("rst_memreq2", 1'b1, v, E_NONE);

    // Single access: four frozen cycles, release pulse on the fifth
    for (int i = 0; i < 4; i++) cyc("acc1_wait", 1'b0, v, E_MEM);
    cyc("acc1_done", 1'b0, v, E_DONE);
    cyc("idle_after", 1'b0, idle, E_NONE);

    // Back-to-back accesses with a branch and a hazard arriving mid-wait
    for (int i = 0; i < 4; i++) begin
      v = idle; v.mreq = 1'b1;
      if (i == 2) begin
        v.br = 1'b1; v.s1 = 4'd3; v.u1 = 1'b1; v.ed = 4'd3; v.ewb = 1'b1; v.erd = 1'b1;
      end
      cyc("acc2_wait", 1'b0, v, E_MEM);
    end
    v = idle; v.mreq = 1'b1;
    cyc("acc2_done", 1'b0, v, E_DONE);
    for (int i = 0; i < 4; i++) cyc("acc3_wait", 1'b0, v, E_MEM);
    cyc("acc3_done", 1'b0, v, E_DONE);

    // RAW hazards
    v = idle; v.s1 = 4'd3; v.u1 = 1'b1; v.ed = 4'd3; v.ewb = 1'b1;
    cyc("raw_exe_alu", 1'b0, v, E_EXE_ALU);
    v.erd = 1'b1;
    cyc("raw_exe_load", 1'b0, v, E_HAZ);
    v.ewb = 1'b0;
    cyc("raw_exe_nowb", 1'b0, v, E_NONE);
    v.ewb = 1'b1; v.u1 = 1'b0;
    cyc("raw_src1_unused", 1'b0, v, E_NONE);
    v = idle; v.s2 = 4'd7; v.two = 1'b1; v.ed = 4'd7; v.ewb = 1'b1; v.erd = 1'b1;
    cyc("raw_src2_load", 1'b0, v, E_HAZ);
    v.ed = 4'd6;
    cyc("raw_src2_diff", 1'b0, v, E_NONE);

    // Branch priority
    v = idle; v.s1 = 4'd3; v.u1 = 1'b1; v.ed = 4'd3; v.ewb = 1'b1; v.erd = 1'b1; v.br = 1'b1;
    cyc("branch_over_hz", 1'b0, v, E_BR);
    v = idle; v.br = 1'b1;
    cyc("branch_only", 1'b0, v, E_BR);

    // MEM-stage producer and load-use on src2
    v = idle; v.s2 = 4'd5; v.two = 1'b1; v.md = 4'd5; v.mwb = 1'b1;
    cyc("mem_stage_dep", 1'b0, v, E_MEM_FWD);
    v.ed = 4'd5; v.ewb = 1'b1; v.erd = 1'b1;
    cyc("load_use_src2", 1'b0, v, E_HAZ);
    v = idle; v.s2 = 4'd5; v.two = 1'b0; v.md = 4'd5; v.mwb = 1'b1;
    cyc("mem_dep_no_src2", 1'b0, v, E_NONE);

    // Reset in the middle of an access releases the freeze immediately
    v = idle; v.mreq = 1'b1;
    cyc("acc4_wait", 1'b0, v, E_MEM);
    cyc("acc4_wait", 1'b0, v, E_MEM);
    cyc("rst_mid_access", 1'b1, v, E_NONE);
    cyc("post_rst_idle", 1'b0, idle, E_NONE);

    // Saturation of the narrow counter under a sustained load-use hazard
    cyc("rst_sat", 1'b1, idle, E_NONE);
    v = idle; v.s1 = 4'd9; v.u1 = 1'b1; v.ed = 4'd9; v.ewb = 1'b1; v.erd = 1'b1;
    for (int i = 0; i < 20; i++) cyc("sat_hz", 1'b0, v, E_HAZ);
    cyc("sat_final", 1'b0, idle, E_NONE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
